// File: rtl/irs_readout_pkg.sv
// Shared definitions for the IRS readout controllers: mode and state encodings,
// default ASIC timing (all values are cycles-1) and the phase-counter width.
package irs_readout_pkg;

   localparam int PHASE_W = 8;

   typedef enum logic [1:0] {
      MODE_LOAD     = 2'b00,
      MODE_INC      = 2'b01,
      MODE_LOAD_INC = 2'b10,
      MODE_RSVD     = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DIR_SETUP  = 3'd1,
      ST_SH_HIGH    = 3'd2,
      ST_SH_LOW     = 3'd3,
      ST_SH_HOLD    = 3'd4,
      ST_INC_HIGH   = 3'd5,
      ST_INC_SETTLE = 3'd6,
      ST_DONE       = 3'd7
   } state_e;

   localparam int DEF_DIR_SETUP  = 10;
   localparam int DEF_SCLK_HIGH  = 10;
   localparam int DEF_SCLK_LOW   = 10;
   localparam int DEF_SHIFT_HOLD = 10;
   localparam int DEF_INC_HIGH   = 1;
   localparam int DEF_INC_SETTLE = 1;

   function automatic logic [PHASE_W-1:0] phase_tc(input int cycles_m1);
      return cycles_m1[PHASE_W-1:0];
   endfunction

endpackage

// File: rtl/irs_phase_timer.sv
// Terminal-count phase timer: counts cycles spent in the current state and
// flags the last one; the owning FSM clears it on every state change.
module irs_phase_timer
   import irs_readout_pkg::*;
#(
   parameter int W = PHASE_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic [W-1:0] tc_i,
   output logic         last_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_r;

   // cycle counter, restarted whenever the FSM changes state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r <= '0;
      end else if (clr_i) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + ONE;
      end
   end

   assign last_o = (cnt_r == tc_i);

endmodule

// File: rtl/irs_address_sequencer.sv
// IRS DO-address sequencer: serially loads a readout address into the ASIC and
// issues increment bursts with a data-latch strobe per increment.
module irs_address_sequencer
   import irs_readout_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int CNT_W      = 10,
   parameter bit MSB_FIRST  = 1'b0,
   parameter int DIR_SETUP  = DEF_DIR_SETUP,
   parameter int SCLK_HIGH  = DEF_SCLK_HIGH,
   parameter int SCLK_LOW   = DEF_SCLK_LOW,
   parameter int SHIFT_HOLD = DEF_SHIFT_HOLD,
   parameter int INC_HIGH   = DEF_INC_HIGH,
   parameter int INC_SETTLE = DEF_INC_SETTLE
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [CNT_W-1:0]  n_incr_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              step_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              do_dir_o,
   output logic              do_sin_o,
   output logic              do_sclk_o
);

   localparam int BIT_W = $clog2(ADDR_W + 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(ADDR_W - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e              state_r, state_s;
   mode_e               mode_r;
   logic [PHASE_W-1:0]  tc_s;
   logic                last_s, clr_s, dir_s;
   logic [ADDR_W-1:0]   shift_r, addr_lat_r, shadow_r;
   logic [CNT_W-1:0]    n_r, inc_cnt_r, inc_nxt_s;
   logic [BIT_W-1:0]    bit_cnt_r;

   assign inc_nxt_s = inc_cnt_r + CNT_ONE;
   assign clr_s     = (state_s != state_r);

   irs_phase_timer #(.W(PHASE_W)) u_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr_s),
      .tc_i   (tc_s),
      .last_o (last_s)
   );

   // per-state dwell length
   always_comb begin
      tc_s = '0;
      case (state_r)
         ST_DIR_SETUP:  tc_s = phase_tc(DIR_SETUP);
         ST_SH_HIGH:    tc_s = phase_tc(SCLK_HIGH);
         ST_SH_LOW:     tc_s = phase_tc(SCLK_LOW);
         ST_SH_HOLD:    tc_s = phase_tc(SHIFT_HOLD);
         ST_INC_HIGH:   tc_s = phase_tc(INC_HIGH);
         ST_INC_SETTLE: tc_s = phase_tc(INC_SETTLE);
         default:       tc_s = '0;
      endcase
   end

   // next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               case (mode_i)
                  MODE_LOAD, MODE_LOAD_INC: state_s = ST_DIR_SETUP;
                  MODE_INC:  state_s = (n_incr_i != '0) ? ST_INC_HIGH : ST_DONE;
                  default:   state_s = ST_DONE;
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DIR_SETUP: state_s = last_s ? ST_SH_HIGH : ST_DIR_SETUP;
         ST_SH_HIGH:   state_s = last_s ? ST_SH_LOW : ST_SH_HIGH;
         ST_SH_LOW: begin
            if (last_s) begin
               state_s = (bit_cnt_r == LAST_BIT) ? ST_SH_HOLD : ST_SH_HIGH;
            end else begin
               state_s = ST_SH_LOW;
            end
         end
         ST_SH_HOLD: begin
            if (last_s) begin
               state_s = (mode_r == MODE_LOAD_INC && n_r != '0) ? ST_INC_HIGH : ST_DONE;
            end else begin
               state_s = ST_SH_HOLD;
            end
         end
         ST_INC_HIGH: state_s = last_s ? ST_INC_SETTLE : ST_INC_HIGH;
         ST_INC_SETTLE: begin
            if (last_s) begin
               state_s = (inc_nxt_s == n_r) ? ST_DONE : ST_INC_HIGH;
            end else begin
               state_s = ST_INC_SETTLE;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // state, operand capture, shifter and shadow address
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         mode_r     <= MODE_LOAD;
         shift_r    <= '0;
         addr_lat_r <= '0;
         shadow_r   <= '0;
         n_r        <= '0;
         inc_cnt_r  <= '0;
         bit_cnt_r  <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  shift_r    <= addr_i;
                  addr_lat_r <= addr_i;
                  n_r        <= n_incr_i;
                  mode_r     <= mode_e'(mode_i);
                  inc_cnt_r  <= '0;
                  bit_cnt_r  <= '0;
               end
            end
            ST_SH_HIGH: begin
               // next bit appears on DO_SIN as SCLK falls
               if (last_s) begin
                  shift_r <= MSB_FIRST ? {shift_r[ADDR_W-2:0], 1'b0}
                                       : {1'b0, shift_r[ADDR_W-1:1]};
               end
            end
            ST_SH_LOW: begin
               if (last_s) begin
                  bit_cnt_r <= bit_cnt_r + BIT_ONE;
               end
            end
            ST_SH_HOLD: begin
               if (last_s) begin
                  shadow_r <= addr_lat_r;
               end
            end
            ST_INC_SETTLE: begin
               if (last_s) begin
                  shadow_r  <= shadow_r + ADDR_ONE;
                  inc_cnt_r <= inc_nxt_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dir_s     = (state_r == ST_DIR_SETUP) || (state_r == ST_SH_HIGH) ||
                      (state_r == ST_SH_LOW)    || (state_r == ST_SH_HOLD);
   assign busy_o    = (state_r != ST_IDLE);
   assign done_o    = (state_r == ST_DONE);
   assign step_o    = (state_r == ST_INC_SETTLE) && last_s;
   assign addr_o    = shadow_r;
   assign do_dir_o  = dir_s;
   assign do_sclk_o = (state_r == ST_SH_HIGH) || (state_r == ST_INC_HIGH);
   assign do_sin_o  = dir_s & (MSB_FIRST ? shift_r[ADDR_W-1] : shift_r[0]);

endmodule

// File: tb/tb_irs_address_sequencer.sv
// Randomised scoreboard bench for irs_address_sequencer: a reference model
// predicts strobe/done timing, shadow addresses and shifted bits per operation.
module tb_irs_address_sequencer;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic [1:0] mode_i = 2'b00;
   logic [8:0] addr_i = 9'h000;
   logic [9:0] n_incr_i = 10'd0;

   logic       busy_o, done_o, step_o, do_dir_o, do_sin_o, do_sclk_o;
   logic [8:0] addr_o;
   logic       m_busy, m_done, m_step, m_dir, m_sin, m_sclk;
   logic [8:0] m_addr;

   irs_address_sequencer dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
      .addr_i(addr_i), .n_incr_i(n_incr_i), .busy_o(busy_o), .done_o(done_o),
      .step_o(step_o), .addr_o(addr_o), .do_dir_o(do_dir_o),
      .do_sin_o(do_sin_o), .do_sclk_o(do_sclk_o)
   );

   irs_address_sequencer #(.MSB_FIRST(1'b1)) dut_msb (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
      .addr_i(addr_i), .n_incr_i(n_incr_i), .busy_o(m_busy), .done_o(m_done),
      .step_o(m_step), .addr_o(m_addr), .do_dir_o(m_dir),
      .do_sin_o(m_sin), .do_sclk_o(m_sclk)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [8:0] addr;
      int         rises;
   } ev_t;

   ev_t  step_q[$];
   ev_t  done_q[$];
   logic bit_q[$];
   logic bit_msb_q[$];

   int         n_checks = 0;
   int         n_fail = 0;
   int         win_t = -1000;
   int         win_done = -1000;
   bit         win_load = 1'b0;
   logic [8:0] model_addr = 9'h000;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: samples 1 time unit after each rising edge
   int   sclk_rises = 0;
   logic sclk_prev = 1'b0;
   logic msb_sclk_prev = 1'b0;
   always @(posedge clk) begin
      ev_t  e;
      logic b;
      bit   exp_busy, exp_dir;
      #1;
      if (rst_i) begin
         step_q.delete();
         done_q.delete();
         bit_q.delete();
         bit_msb_q.delete();
         sclk_rises = 0;
         sclk_prev = 1'b0;
         msb_sclk_prev = 1'b0;
         check({busy_o, done_o, step_o, do_dir_o, do_sin_o, do_sclk_o, addr_o} == 15'd0,
               "reset_outputs", int'({busy_o, done_o, step_o, do_dir_o, do_sin_o, do_sclk_o, addr_o}), 0);
      end else begin
         exp_busy = (cyc > win_t) && (cyc <= win_done);
         exp_dir  = win_load && (cyc > win_t) && (cyc <= win_t + 220);
         check(busy_o == exp_busy, "busy", int'(busy_o), int'(exp_busy));
         check(do_dir_o == exp_dir, "do_dir", int'(do_dir_o), int'(exp_dir));
         if (do_sclk_o && !sclk_prev) begin
            sclk_rises++;
            if (do_dir_o) begin
               if (bit_q.size() == 0) begin
                  check(1'b0, "sin_unexpected_bit", 1, 0);
               end else begin
                  b = bit_q.pop_front();
                  check(do_sin_o == b, "sin_lsb_first", int'(do_sin_o), int'(b));
               end
            end
         end
         if (m_sclk && !msb_sclk_prev && m_dir) begin
            if (bit_msb_q.size() == 0) begin
               check(1'b0, "msb_unexpected_bit", 1, 0);
            end else begin
               b = bit_msb_q.pop_front();
               check(m_sin == b, "sin_msb_first", int'(m_sin), int'(b));
            end
         end
         if (step_o) begin
            if (step_q.size() == 0) begin
               check(1'b0, "step_unexpected", 1, 0);
            end else begin
               e = step_q.pop_front();
               check(cyc == e.t, "step_time", cyc, e.t);
               check(addr_o == e.addr, "step_addr", int'(addr_o), int'(e.addr));
            end
         end
         if (done_o) begin
            if (done_q.size() == 0) begin
               check(1'b0, "done_unexpected", 1, 0);
            end else begin
               e = done_q.pop_front();
               check(cyc == e.t, "done_time", cyc, e.t);
               check(addr_o == e.addr, "done_addr", int'(addr_o), int'(e.addr));
               check(m_addr == e.addr, "msb_done_addr", int'(m_addr), int'(e.addr));
               check(sclk_rises == e.rises, "sclk_rises", sclk_rises, e.rises);
               check(bit_q.size() == 0, "bits_left", bit_q.size(), 0);
            end
            sclk_rises = 0;
         end
         sclk_prev = do_sclk_o;
         msb_sclk_prev = m_sclk;
      end
   end

   // issue one operation at a falling edge; the model predicts every event
   task automatic do_op(input logic [1:0] m, input logic [8:0] a, input int n,
                        input bit poke, input int abort);
      int         t0, t;
      bit         load, inc;
      logic [8:0] s;
      ev_t        e;
      t0 = cyc;
      start_i  = 1'b1;
      mode_i   = m;
      addr_i   = a;
      n_incr_i = n[9:0];
      load = (m == 2'b00) || (m == 2'b10);
      inc  = (m == 2'b01) || (m == 2'b10);
      t = t0;
      s = model_addr;
      if (load) begin
         for (int i = 0; i < 9; i++) begin
            bit_q.push_back(a[i]);
            bit_msb_q.push_back(a[8-i]);
         end
         t = t + 11 + 9 * 22 + 11;
         s = a;
      end
      if (inc) begin
         for (int k = 0; k < n; k++) begin
            t = t + 4;
            e.t = t; e.addr = s; e.rises = 0;
            step_q.push_back(e);
            s = s + 9'd1;
         end
      end
      e.t = t + 1; e.addr = s; e.rises = (load ? 9 : 0) + (inc ? n : 0);
      done_q.push_back(e);
      model_addr = s;
      win_t = t0;
      win_done = t + 1;
      win_load = load;
      @(negedge clk);
      start_i  = 1'b0;
      mode_i   = 2'($urandom);
      addr_i   = 9'($urandom);
      n_incr_i = 10'($urandom);
      if (abort > 0) begin
         repeat (abort - 1) @(negedge clk);
         rst_i = 1'b1;
         win_t = -1000;
         win_done = -1000;
         win_load = 1'b0;
         model_addr = 9'h000;
         @(negedge clk);
         rst_i = 1'b0;
         repeat (250) @(negedge clk);
      end else begin
         if (poke && (t + 1 >= t0 + 6)) begin
            repeat (3) @(negedge clk);
            start_i  = 1'b1;
            mode_i   = 2'($urandom);
            addr_i   = 9'($urandom);
            n_incr_i = 10'($urandom_range(0, 7));
            @(negedge clk);
            start_i = 1'b0;
         end
         while (cyc < t + 2) @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      do_op(2'b00, 9'h0A5, 0, 1'b0, 0);
      do_op(2'b00, 9'h100, 0, 1'b0, 0);
      do_op(2'b01, 9'h000, 3, 1'b0, 0);
      do_op(2'b10, 9'h1FE, 4, 1'b0, 0);
      do_op(2'b01, 9'h033, 0, 1'b0, 0);
      do_op(2'b11, 9'h055, 5, 1'b0, 0);
      do_op(2'b00, 9'h1C3, 0, 1'b1, 0);
      do_op(2'b01, 9'h000, 5, 1'b1, 0);
      do_op(2'b10, 9'h0F0, 2, 1'b0, 60);
      do_op(2'b01, 9'h000, 2, 1'b0, 0);
      for (int i = 0; i < 20; i++) begin
         do_op(2'($urandom_range(0, 3)), 9'($urandom), $urandom_range(0, 6),
               ($urandom_range(0, 3) == 0), 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check(step_q.size() == 0, "steps_outstanding", step_q.size(), 0);
      check(done_q.size() == 0, "dones_outstanding", done_q.size(), 0);
      check(bit_msb_q.size() == 0, "msb_bits_left", bit_msb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
